// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative divider and the execute stage that drives it.
package div_iter_pkg;

    // Divider FSM states.
    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_t;

    localparam logic        RstEnable         = 1'b1;
    localparam logic        WriteEnable       = 1'b1;
    localparam logic [31:0] ZeroWord          = 32'h0000_0000;

    localparam logic        DivResultReady    = 1'b1;
    localparam logic        DivResultNotReady = 1'b0;
    localparam logic        DivStart          = 1'b1;
    localparam logic        DivStop           = 1'b0;

    localparam logic [7:0]  EXE_DIV_OP        = 8'b0001_1010;
    localparam logic [7:0]  EXE_DIVU_OP       = 8'b0001_1011;

endpackage

// File: rtl/div_iter_if.sv
// Request/response bundle between the execute stage (master) and the divider (slave).
interface div_iter_if #(parameter int WIDTH = 32);
    logic                 signed_div_i;
    logic [WIDTH-1:0]     opdata1_i;
    logic [WIDTH-1:0]     opdata2_i;
    logic                 start_i;
    logic                 annul_i;
    logic [2*WIDTH-1:0]   result_o;
    logic                 ready_o;
    logic                 div_by_zero_o;
    logic                 stallreq_o;

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, div_by_zero_o, stallreq_o
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, div_by_zero_o, stallreq_o
    );
endinterface

// File: rtl/div_iter.sv
// Multi-cycle radix-2 restoring divider: one quotient bit per clock, signed
// operands handled as magnitudes with sign fix-up on the way into DivEnd.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// DivFree   | idle, waiting for start_i with annul_i low
// DivByZero | divisor was zero, result is produced on the next edge
// DivOn     | shift/trial-subtract iterations, counter counts 0..WIDTH
// DivEnd    | result valid, held until start_i drops or annul_i
module div_iter
    import div_iter_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic      clk,
    input  logic      rst,
    div_iter_if.slave bus
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t          state, state_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [WIDTH-1:0]    rem, rem_nxt;
    logic [WIDTH-1:0]    quo, quo_nxt;
    logic [WIDTH-1:0]    dvs, dvs_nxt;
    logic                sign_dvd, sign_dvd_nxt;
    logic                sign_dvs, sign_dvs_nxt;
    logic [2*WIDTH-1:0]  result, result_nxt;
    logic                ready, ready_nxt;
    logic                dbz, dbz_nxt;

    logic [WIDTH-1:0]    abs_dvd, abs_dvs;
    logic [WIDTH:0]      shifted, diff;
    logic                take;
    logic [WIDTH-1:0]    quo_fix, rem_fix;

    // Operand magnitudes; signs only matter in signed mode.
    assign abs_dvd = (bus.signed_div_i & bus.opdata1_i[WIDTH-1]) ? -bus.opdata1_i : bus.opdata1_i;
    assign abs_dvs = (bus.signed_div_i & bus.opdata2_i[WIDTH-1]) ? -bus.opdata2_i : bus.opdata2_i;

    // Partial remainder stays below the divisor, so the borrow out of the
    // WIDTH+1 bit subtract alone tells whether the trial subtract succeeds.
    assign shifted = {rem, quo[WIDTH-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign take    = ~diff[WIDTH];

    assign quo_fix = (sign_dvd ^ sign_dvs) ? -quo : quo;
    assign rem_fix = sign_dvd ? -rem : rem;

    assign bus.result_o      = result;
    assign bus.ready_o       = ready;
    assign bus.div_by_zero_o = dbz;
    assign bus.stallreq_o    = bus.start_i & ~bus.annul_i & ~ready;

    // Next-state and datapath update; annul_i always wins over start_i.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rem_nxt      = rem;
        quo_nxt      = quo;
        dvs_nxt      = dvs;
        sign_dvd_nxt = sign_dvd;
        sign_dvs_nxt = sign_dvs;
        result_nxt   = result;
        ready_nxt    = ready;
        dbz_nxt      = dbz;
        case (state)
            DivFree: begin
                if (bus.start_i == DivStart && !bus.annul_i) begin
                    if (bus.opdata2_i == '0) begin
                        state_nxt = DivByZero;
                    end else begin
                        state_nxt    = DivOn;
                        cnt_nxt      = '0;
                        rem_nxt      = '0;
                        quo_nxt      = abs_dvd;
                        dvs_nxt      = abs_dvs;
                        sign_dvd_nxt = bus.signed_div_i & bus.opdata1_i[WIDTH-1];
                        sign_dvs_nxt = bus.signed_div_i & bus.opdata2_i[WIDTH-1];
                    end
                end
            end
            DivByZero: begin
                if (bus.annul_i) begin
                    state_nxt = DivFree;
                end else begin
                    state_nxt  = DivEnd;
                    result_nxt = '0;
                    dbz_nxt    = 1'b1;
                    ready_nxt  = DivResultReady;
                end
            end
            DivOn: begin
                if (bus.annul_i) begin
                    state_nxt = DivFree;
                end else if (cnt == CW'(WIDTH)) begin
                    state_nxt  = DivEnd;
                    result_nxt = {rem_fix, quo_fix};
                    ready_nxt  = DivResultReady;
                end else begin
                    rem_nxt = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
                    quo_nxt = {quo[WIDTH-2:0], take};
                    cnt_nxt = cnt + 1'b1;
                end
            end
            DivEnd: begin
                if (bus.annul_i || bus.start_i == DivStop) begin
                    state_nxt  = DivFree;
                    result_nxt = '0;
                    ready_nxt  = DivResultNotReady;
                    dbz_nxt    = 1'b0;
                end
            end
            default: state_nxt = DivFree;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state    <= DivFree;
            cnt      <= '0;
            rem      <= '0;
            quo      <= '0;
            dvs      <= '0;
            sign_dvd <= 1'b0;
            sign_dvs <= 1'b0;
            result   <= '0;
            ready    <= DivResultNotReady;
            dbz      <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            rem      <= rem_nxt;
            quo      <= quo_nxt;
            dvs      <= dvs_nxt;
            sign_dvd <= sign_dvd_nxt;
            sign_dvs <= sign_dvs_nxt;
            result   <= result_nxt;
            ready    <= ready_nxt;
            dbz      <= dbz_nxt;
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter at WIDTH=32: latency, signed/unsigned results,
// divide-by-zero, overflow, annul and mid-operation reset.
module tb_div_iter;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    div_iter_if #(.WIDTH(32)) bus();

    div_iter #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Drive a request at a negedge and count rising edges until ready_o is seen.
    task automatic run_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                           output int edges, output logic stall_ok);
        @(negedge clk);
        bus.signed_div_i = sgn;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.annul_i      = 1'b0;
        bus.start_i      = 1'b1;
        #1;
        edges    = 0;
        stall_ok = 1'b1;
        while (bus.ready_o !== 1'b1 && edges < 100) begin
            if (bus.stallreq_o !== 1'b1) stall_ok = 1'b0;
            @(posedge clk);
            edges++;
            @(negedge clk);
        end
        if (bus.stallreq_o !== 1'b0) stall_ok = 1'b0;
    endtask

    task automatic drop_start();
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = '0;
        bus.opdata2_i    = '0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({bus.ready_o, bus.div_by_zero_o, bus.stallreq_o, bus.result_o} !== 67'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b dbz=%b stall=%b res=%h want all zero",
                     bus.ready_o, bus.div_by_zero_o, bus.stallreq_o, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned();
        int   e;
        logic s;
        logic [63:0] held;
        run_div(1'b0, 32'd100, 32'd7, e, s);
        total++;
        if (e !== 34) begin
            bad++;
            $display("FAIL udiv_latency: got %0d edges want 34", e);
        end
        total++;
        if (bus.result_o !== 64'h00000002_0000000E) begin
            bad++;
            $display("FAIL udiv_result: got %h want 000000020000000e", bus.result_o);
        end
        total++;
        if (bus.div_by_zero_o !== 1'b0) begin
            bad++;
            $display("FAIL udiv_dbz: got %b want 0", bus.div_by_zero_o);
        end
        total++;
        if (s !== 1'b1) begin
            bad++;
            $display("FAIL udiv_stallreq: got stall profile ok=%b want 1", s);
        end
        held = bus.result_o;
        bus.opdata1_i = 32'd55;
        bus.opdata2_i = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (bus.ready_o !== 1'b1 || bus.result_o !== 64'h00000002_0000000E) begin
            bad++;
            $display("FAIL udiv_hold: got rdy=%b res=%h want rdy=1 res=%h", bus.ready_o, bus.result_o, held);
        end
        drop_start();
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL udiv_release: got rdy=%b res=%h want rdy=0 res=0", bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_signed();
        logic        sg  [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
        logic [31:0] av  [4] = '{32'hFFFFFFF9, 32'h00000007, 32'hFFFFFFF9, 32'hFFFFFFF9};
        logic [31:0] bv  [4] = '{32'h00000002, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h00000002};
        logic [63:0] exp [4] = '{64'hFFFFFFFF_FFFFFFFD, 64'h00000001_FFFFFFFD,
                                 64'hFFFFFFFF_00000003, 64'h00000001_7FFFFFFC};
        for (int i = 0; i < 4; i++) begin
            int   e;
            logic s;
            run_div(sg[i], av[i], bv[i], e, s);
            total++;
            if (e !== 34 || bus.result_o !== exp[i]) begin
                bad++;
                $display("FAIL signed_vec%0d: got edges=%0d res=%h want edges=34 res=%h",
                         i, e, bus.result_o, exp[i]);
            end
            drop_start();
        end
    endtask

    task automatic test_div_zero();
        int   e;
        logic s;
        run_div(1'b0, 32'h1234, 32'h0, e, s);
        total++;
        if (e !== 2) begin
            bad++;
            $display("FAIL dbz_latency: got %0d edges want 2", e);
        end
        total++;
        if (bus.result_o !== 64'h0 || bus.div_by_zero_o !== 1'b1) begin
            bad++;
            $display("FAIL dbz_result: got res=%h dbz=%b want res=0 dbz=1", bus.result_o, bus.div_by_zero_o);
        end
        drop_start();
        total++;
        if (bus.ready_o !== 1'b0 || bus.div_by_zero_o !== 1'b0) begin
            bad++;
            $display("FAIL dbz_release: got rdy=%b dbz=%b want 0 0", bus.ready_o, bus.div_by_zero_o);
        end
    endtask

    task automatic test_boundary();
        int   e;
        logic s;
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, e, s);
        total++;
        if (bus.result_o !== 64'h00000000_80000000 || bus.div_by_zero_o !== 1'b0) begin
            bad++;
            $display("FAIL overflow: got res=%h dbz=%b want 0000000080000000 0", bus.result_o, bus.div_by_zero_o);
        end
        drop_start();
        run_div(1'b0, 32'hFFFFFFFF, 32'h00000001, e, s);
        total++;
        if (bus.result_o !== 64'h00000000_FFFFFFFF) begin
            bad++;
            $display("FAIL umax_by_one: got %h want 00000000ffffffff", bus.result_o);
        end
        drop_start();
    endtask

    task automatic test_annul();
        int   e;
        logic s;
        logic seen;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.ready_o === 1'b1) seen = 1'b1;
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL annul_on: got ready asserted=%b want 0", seen);
        end
        bus.opdata1_i = 32'd9;
        bus.opdata2_i = 32'd3;
        bus.start_i   = 1'b1;
        bus.annul_i   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
            bad++;
            $display("FAIL annul_idle: got rdy=%b stall=%b want 0 0", bus.ready_o, bus.stallreq_o);
        end
        run_div(1'b0, 32'd9, 32'd3, e, s);
        total++;
        if (e !== 34 || bus.result_o !== 64'h00000000_00000003) begin
            bad++;
            $display("FAIL after_annul: got edges=%0d res=%h want edges=34 res=0000000000000003", e, bus.result_o);
        end
        @(negedge clk);
        bus.annul_i = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL annul_end: got rdy=%b res=%h want 0 0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int   e;
        logic s;
        @(negedge clk);
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd100;
        bus.opdata2_i    = 32'd7;
        bus.start_i      = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0 || bus.div_by_zero_o !== 1'b0) begin
            bad++;
            $display("FAIL reset_on: got rdy=%b res=%h dbz=%b want 0", bus.ready_o, bus.result_o, bus.div_by_zero_o);
        end
        @(negedge clk);
        rst = 1'b0;
        run_div(1'b0, 32'd100, 32'd7, e, s);
        total++;
        if (e !== 34 || bus.result_o !== 64'h00000002_0000000E) begin
            bad++;
            $display("FAIL restart: got edges=%0d res=%h want edges=34 res=000000020000000e", e, bus.result_o);
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'h0) begin
            bad++;
            $display("FAIL reset_end: got rdy=%b res=%h want 0 0", bus.ready_o, bus.result_o);
        end
        @(negedge clk);
        rst         = 1'b0;
        bus.start_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_div_zero();
        test_boundary();
        test_annul();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/div_iter.md
Name: div_iter

Overview:
- Parametrised multi-cycle radix-2 restoring divider for the execute stage.
- Serves DIV/DIVU: quotient goes to LO and remainder goes to HI on completion.
- Holds the pipeline via stallreq_o while busy.
- Adds over the single-cycle execute datapath: configurable operand width, signed/unsigned mode, start/annul handshake, divide-by-zero detection and registered results.

Parameters:
- WIDTH, 32, operand width in bits; any value >= 4. The counter width is derived as clog2(WIDTH+1).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at accept
- opdata1_i  in  WIDTH  dividend; sampled at accept
- opdata2_i  in  WIDTH  divisor; sampled at accept
- start_i  in  1  request; must be held high until ready_o is seen
- annul_i  in  1  abort, e.g. the instruction was flushed or squashed by an exception
- result_o  out  2*WIDTH  {remainder, quotient}; valid only while ready_o=1
- ready_o  out  1  result valid
- div_by_zero_o  out  1  qualifies result_o when the divisor was 0
- stallreq_o  out  1  combinational stall request to pipeline control

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; result_o=0, ready_o=0, div_by_zero_o=0, counter=0, operand registers=0. Reset mid-operation discards all work.
- States: IDLE, BYZERO, ON, END.
- IDLE:
  - Accept when start_i=1 and annul_i=0.
  - Divisor==0 -> BYZERO.
  - Otherwise capture operands and go to ON with counter=0.
  - Signed mode: capture |dividend| and |divisor| as unsigned magnitudes, and record the sign of each.
- BYZERO: next edge -> END with result_o=0 and div_by_zero_o=1.
- ON:
  - Each edge performs one shift/trial-subtract on the {partial remainder, dividend} register pair.
  - A non-negative difference sets the quotient bit to 1 and keeps the difference.
  - The counter increments; after WIDTH iterations -> END.
- Sign correction on entry to END, signed mode only:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Unsigned mode: no correction.
- END:
  - ready_o=1 and result_o is held.
  - When start_i falls -> IDLE: ready_o=0, result_o=0, div_by_zero_o=0.
  - While start_i stays high, remain in END (pipeline stall release cycle).
- Latency (divisor non-zero): the accept edge is E0 and iterations occur at E1..E_WIDTH. ready_o is high in the cycle after edge E_WIDTH+1, i.e. 34 edges for WIDTH=32.
- Latency (divisor zero): ready_o is high after E1.
- Annul:
  - annul_i=1 in BYZERO or ON -> IDLE on the next edge, with ready_o=0 and no result.
  - annul_i=1 in IDLE blocks accept.
  - annul_i=1 in END -> IDLE.
  - Annul takes priority over start_i.
- start_i and operand changes while in BYZERO/ON/END are ignored; operands are not resampled.
- Overflow (signed most-negative / -1): quotient wraps to the most-negative value, remainder=0. No trap is raised.
- stallreq_o = start_i & ~annul_i & ~ready_o.
- Arithmetic: the partial remainder and subtract path are WIDTH+1 bits wide. Negation is two's complement in WIDTH bits.

Decomposition:
- The shared defines file gains:
  - state encodings DivFree, DivByZero, DivOn, DivEnd
  - DivResultReady/DivResultNotReady
  - DivStart/DivStop
  - EXE_DIV_OP/EXE_DIVU_OP
- Existing RstEnable, ZeroWord and WriteEnable are reused.
- No sub-module is needed. The execute stage instantiates div_iter and maps result_o[2*WIDTH-1:WIDTH] to hi_o and result_o[WIDTH-1:0] to lo_o, with whilo_o=1 when ready_o=1.

Test Plan (WIDTH=32):
- Unsigned 100/7, start held -> ready_o rises 34 edges after accept; result_o=0x00000002_0000000E; div_by_zero_o=0; stallreq_o=1 until ready.
- Signed -7/2 (0xFFFFFFF9 / 0x00000002) -> result_o=0xFFFFFFFF_FFFFFFFD (q=-3, r=-1). Also signed 7/-2 -> 0x00000001_FFFFFFFD.
- Divisor 0 (dividend 0x1234) -> ready_o after 2 edges; result_o=0; div_by_zero_o=1; drop start_i -> IDLE with ready_o=0 next edge.
- Signed 0x80000000 / 0xFFFFFFFF -> result_o=0x00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 0x00000000_FFFFFFFF.
- annul_i pulsed at iteration 10 of 100/7 -> IDLE next edge, ready_o never asserts. Then an immediate new start 9/3 -> 0x00000000_00000003.
- rst asserted mid-ON (iteration 5) -> all outputs 0 next edge, state IDLE. A restart then completes with full 34-edge latency.
